// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the main-memory arbiter.
//   FILL_WORDS : 16-bit words moved per cache block fill.
//   MEM_LAT    : cycles from a read issue to mem_data_valid for that word.
//   state_t    : arbiter FSM states.
//   owner_t    : last fill owner, used only when MEM_ARB_RR_EN is defined.
package mem_arb_pkg;

  localparam int FILL_WORDS = 8;
  localparam int MEM_LAT    = 4;
  localparam int CNT_W      = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t FILL_CNT = cnt_t'(FILL_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    FILL_I,
    FILL_D,
    DRAIN
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/arb_xfer_counter.sv
// arb_xfer_counter
//   Issue/beat counter pair for one block fill. Both counters clear together,
//   saturate at FILL_WORDS and never wrap.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     clr                   synchronous clear of both counters
//     issue_inc, beat_inc   count one read issue / one returned beat
//     issue_cnt, beat_cnt   current counts
//     issue_done, beat_done count is at FILL_WORDS once this cycle's update lands
module arb_xfer_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             issue_inc,
  input  logic             beat_inc,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             issue_done,
  output logic             beat_done
);

  // Look-ahead flags let the owner react in the same cycle as the final event.
  assign issue_done = (issue_cnt == FILL_CNT) ||
                      (issue_inc && (issue_cnt == FILL_CNT - 1'b1));
  assign beat_done  = (beat_cnt == FILL_CNT) ||
                      (beat_inc && (beat_cnt == FILL_CNT - 1'b1));

  // NOTE: registers update with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      beat_cnt  <= '0;
    end else if (clr) begin
      issue_cnt <= '0;
      beat_cnt  <= '0;
    end else begin
      if (issue_inc && (issue_cnt != FILL_CNT)) issue_cnt <= issue_cnt + 1'b1;
      if (beat_inc && (beat_cnt != FILL_CNT))   beat_cnt  <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the multicycle main memory between the I-cache fill FSM, the
//   D-cache fill FSM and D-cache write-through stores. One 8-word fill or one
//   single-word store owns the memory at a time.
//   Build option: MEM_ARB_RR_EN defined -> round-robin between simultaneous
//   fills (D wins the first tie); undefined -> D fill always beats I fill.
//   Stores beat fills in both builds.
//   Ports:
//     clk, rst_n                   clock, asynchronous active-low reset
//     i_miss, d_miss               fill requests, held until block written
//     i_fill_addr, d_fill_addr     address driven by each fill FSM
//     d_wr_req/addr/data           store request, held until d_wr_ack
//     mem_data_valid               read word returned by memory
//     mem_enable, mem_wr           memory strobe / write select
//     mem_addr, mem_wdata          memory address / write data
//     i_grant, d_grant             current fill owner
//     i_data_valid, d_data_valid   mem_data_valid routed to the owner
//     i_force_reset, d_force_reset hold non-owning fill FSMs in reset
//     d_wr_ack                     store accepted this cycle
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic        d_miss,
  input  logic [15:0] i_fill_addr,
  input  logic [15:0] d_fill_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        i_grant,
  output logic        d_grant,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic        i_force_reset,
  output logic        d_force_reset,
  output logic        d_wr_ack
);

  state_t state;
  logic   en_q;        // read issue allowed this cycle; low in the grant cycle
`ifdef MEM_ARB_RR_EN
  owner_t last_owner;
`endif

  logic             in_fill;
  logic             fill_miss;
  logic             take_d;
  logic             clr;
  logic             issue_inc;
  logic             beat_inc;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] beat_cnt;
  logic             issue_done;
  logic             beat_done;
  logic             last_beat;
  logic             drain_done;

  assign i_grant   = (state == FILL_I);
  assign d_grant   = (state == FILL_D);
  assign in_fill   = i_grant | d_grant;
  assign fill_miss = (i_grant & i_miss) | (d_grant & d_miss);

  // Dropping the miss kills the strobe in the same cycle, not one later.
  assign mem_enable = (state == WRITE) | (in_fill & en_q & fill_miss);
  assign mem_wr     = (state == WRITE);
  assign d_wr_ack   = (state == WRITE);
  assign mem_wdata  = mem_wr ? d_wr_data : '0;

  // NOTE: default assignment first so no path through the block infers a latch.
  always_comb begin
    mem_addr = '0;
    case (state)
      WRITE:   mem_addr = d_wr_addr;
      FILL_I:  mem_addr = i_fill_addr;
      FILL_D:  mem_addr = d_fill_addr;
      default: mem_addr = '0;
    endcase
  end

  // Beats seen in DRAIN are counted but never routed.
  assign i_data_valid = i_grant & mem_data_valid;
  assign d_data_valid = d_grant & mem_data_valid;

  assign i_force_reset = i_miss & ~i_grant;
  assign d_force_reset = d_miss & ~d_grant;

  assign clr        = (state == IDLE);
  assign issue_inc  = in_fill & mem_enable;
  assign beat_inc   = (in_fill | (state == DRAIN)) & mem_data_valid;
  assign last_beat  = in_fill & beat_done;
  assign drain_done = ((beat_cnt + CNT_W'(beat_inc)) == issue_cnt);

`ifdef MEM_ARB_RR_EN
  assign take_d = d_miss & (~i_miss | (last_owner == OWN_I));
`else
  assign take_d = d_miss;
`endif

  arb_xfer_counter u_xfer_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .issue_inc  (issue_inc),
    .beat_inc   (beat_inc),
    .issue_cnt  (issue_cnt),
    .beat_cnt   (beat_cnt),
    .issue_done (issue_done),
    .beat_done  (beat_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      en_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner <= OWN_I;
`endif
    end else begin
      en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (d_wr_req)    state <= WRITE;
          else if (take_d) state <= FILL_D;
          else if (i_miss) state <= FILL_I;
        end
        WRITE: state <= IDLE;
        FILL_I, FILL_D: begin
          if (last_beat) begin
            state <= IDLE;
`ifdef MEM_ARB_RR_EN
            last_owner <= (state == FILL_I) ? OWN_I : OWN_D;
`endif
          end else if (!fill_miss) begin
            state <= DRAIN;
          end else begin
            en_q <= ~issue_done;
          end
        end
        DRAIN: if (drain_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Scoreboard bench for mem_arbiter. Stimulus pushes the expected output
//   events (grant edges, reads, writes, acks, routed beats) with their cycle
//   numbers into a queue kept sorted by cycle; a negedge monitor pops and
//   compares each event the DUT presents. A MEM_LAT read pipeline models the
//   memory and simple offset counters model the fill FSM addresses.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [15:0] I_BASE = 16'h1234;
  localparam logic [15:0] D_BASE = 16'h4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 1'b0;
  logic        d_miss = 1'b0;
  logic [15:0] i_fill_addr;
  logic [15:0] d_fill_addr;
  logic        d_wr_req = 1'b0;
  logic [15:0] d_wr_addr = '0;
  logic [15:0] d_wr_data = '0;
  logic        mem_data_valid;
  logic        mem_enable, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        i_grant, d_grant, i_data_valid, d_data_valid;
  logic        i_force_reset, d_force_reset, d_wr_ack;

  mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_miss         (i_miss),
    .d_miss         (d_miss),
    .i_fill_addr    (i_fill_addr),
    .d_fill_addr    (d_fill_addr),
    .d_wr_req       (d_wr_req),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .mem_data_valid (mem_data_valid),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .i_grant        (i_grant),
    .d_grant        (d_grant),
    .i_data_valid   (i_data_valid),
    .d_data_valid   (d_data_valid),
    .i_force_reset  (i_force_reset),
    .d_force_reset  (d_force_reset),
    .d_wr_ack       (d_wr_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: a read issued in cycle k returns its beat in cycle k+MEM_LAT.
  logic [MEM_LAT-1:0] rd_pipe;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) rd_pipe <= '0;
    else        rd_pipe <= {rd_pipe[MEM_LAT-2:0], mem_enable & ~mem_wr};
  assign mem_data_valid = rd_pipe[MEM_LAT-1];

  // Fill FSMs: address = base + words issued while granted.
  logic [3:0] i_off, d_off;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i_off <= '0;
      d_off <= '0;
    end else begin
      i_off <= !i_grant ? 4'd0 : i_off + {3'b0, mem_enable};
      d_off <= !d_grant ? 4'd0 : d_off + {3'b0, mem_enable};
    end
  assign i_fill_addr = I_BASE + {12'b0, i_off};
  assign d_fill_addr = D_BASE + {12'b0, d_off};

  typedef enum logic [3:0] {
    EV_GI, EV_GD, EV_RELI, EV_RELD, EV_WR, EV_ACK, EV_RD, EV_IDV, EV_DDV
  } ev_kind_t;

  typedef struct packed {
    ev_kind_t    kind;
    logic [31:0] cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Insert keeping the queue ordered by (cycle, kind), the monitor's order.
  function automatic void expect_ev(ev_kind_t k, int c, logic [15:0] a, logic [15:0] d);
    ev_t e;
    int  idx;
    e   = '{kind: k, cyc: 32'(c), addr: a, data: d};
    idx = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if ({exp_q[i].cyc, exp_q[i].kind} > {e.cyc, e.kind}) begin
        idx = i;
        break;
      end
    end
    exp_q.insert(idx, e);
  endfunction

  // Request sampled in IDLE at cycle t: grant t+1, reads t+2..t+9,
  // beats t+6..t+13, grant falls t+14.
  function automatic void expect_fill(bit is_d, int t, logic [15:0] base);
    int g;
    g = t + 1;
    expect_ev(is_d ? EV_GD : EV_GI, g, '0, '0);
    for (int w = 0; w < FILL_WORDS; w++) begin
      expect_ev(EV_RD, g + 1 + w, base + 16'(w), '0);
      expect_ev(is_d ? EV_DDV : EV_IDV, g + 1 + MEM_LAT + w, '0, '0);
    end
    expect_ev(is_d ? EV_RELD : EV_RELI, g + 1 + MEM_LAT + FILL_WORDS, '0, '0);
  endfunction

  task automatic observe(input ev_kind_t k, input logic [15:0] a, input logic [15:0] d);
    ev_t got;
    ev_t e;
    got = '{kind: k, cyc: 32'(cyc), addr: a, data: d};
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected %s at cycle %0d addr %h data %h, nothing expected",
               k.name(), cyc, a, d);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("event %s", e.kind.name()), got, e);
    end
  endtask

  logic prev_ig = 1'b0;
  logic prev_dg = 1'b0;
  always @(negedge clk) begin
    if (i_grant & ~prev_ig)  observe(EV_GI, '0, '0);
    if (d_grant & ~prev_dg)  observe(EV_GD, '0, '0);
    if (~i_grant & prev_ig)  observe(EV_RELI, '0, '0);
    if (~d_grant & prev_dg)  observe(EV_RELD, '0, '0);
    if (mem_enable & mem_wr) observe(EV_WR, mem_addr, mem_wdata);
    if (d_wr_ack)            observe(EV_ACK, '0, '0);
    if (mem_enable & ~mem_wr) observe(EV_RD, mem_addr, '0);
    if (i_data_valid)        observe(EV_IDV, '0, '0);
    if (d_data_valid)        observe(EV_DDV, '0, '0);
    prev_ig <= i_grant;
    prev_dg <= d_grant;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t;
    bit  own_d;
    ev_t e;

    // Reset values, with i_miss high to see force_reset follow miss.
    i_miss = 1'b1;
    step(3);
    check("rst mem_enable",    mem_enable,    1'b0);
    check("rst mem_wr",        mem_wr,        1'b0);
    check("rst mem_addr",      mem_addr,      16'h0000);
    check("rst mem_wdata",     mem_wdata,     16'h0000);
    check("rst i_grant",       i_grant,       1'b0);
    check("rst d_grant",       d_grant,       1'b0);
    check("rst d_wr_ack",      d_wr_ack,      1'b0);
    check("rst i_data_valid",  i_data_valid,  1'b0);
    check("rst d_data_valid",  d_data_valid,  1'b0);
    check("rst i_force_reset", i_force_reset, 1'b1);
    check("rst d_force_reset", d_force_reset, 1'b0);
    i_miss = 1'b0;
    rst_n  = 1'b1;
    step(2);

    // Single I miss.
    t = cyc;
    i_miss = 1'b1;
    expect_fill(1'b0, t, I_BASE);
    wait_until(t + 14);
    i_miss = 1'b0;
    step(3);

    // Tie from reset, both misses held across three fills.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    t = cyc;
    i_miss = 1'b1;
    d_miss = 1'b1;
    for (int k = 0; k < 3; k++) begin
      own_d = RR ? (k % 2 == 0) : 1'b1;
      expect_fill(own_d, t + 14 * k, own_d ? D_BASE : I_BASE);
    end
    wait_until(t + 5);
    check("tie1 i_force_reset", i_force_reset, 1'b1);
    wait_until(t + 20);
    check("tie2 i_force_reset", i_force_reset, RR ? 1'b0 : 1'b1);
    check("tie2 d_force_reset", d_force_reset, RR ? 1'b1 : 1'b0);
    wait_until(t + 42);
    i_miss = 1'b0;
    d_miss = 1'b0;
    step(2);

    // Store raised during a D fill waits for the fill to finish.
    t = cyc;
    d_miss = 1'b1;
    expect_fill(1'b1, t, D_BASE);
    expect_ev(EV_WR,  t + 15, 16'h00A0, 16'hBEEF);
    expect_ev(EV_ACK, t + 15, '0, '0);
    wait_until(t + 5);
    d_wr_req  = 1'b1;
    d_wr_addr = 16'h00A0;
    d_wr_data = 16'hBEEF;
    wait_until(t + 14);
    d_miss = 1'b0;
    wait_until(t + 16);
    d_wr_req = 1'b0;
    step(2);

    // Store and I miss in the same IDLE cycle.
    t = cyc;
    d_wr_req  = 1'b1;
    d_wr_addr = 16'h0055;
    d_wr_data = 16'h1357;
    i_miss    = 1'b1;
    expect_ev(EV_WR,  t + 1, 16'h0055, 16'h1357);
    expect_ev(EV_ACK, t + 1, '0, '0);
    expect_fill(1'b0, t + 2, I_BASE);
    #1;
    check("wr0 i_force_reset", i_force_reset, 1'b1);
    wait_until(t + 1);
    check("wr1 i_force_reset", i_force_reset, 1'b1);
    wait_until(t + 2);
    d_wr_req = 1'b0;
    #1;
    check("wr2 i_force_reset", i_force_reset, 1'b1);
    wait_until(t + 16);
    i_miss = 1'b0;
    step(2);

    // I miss dropped after three issues; D miss raised during DRAIN.
    t = cyc;
    i_miss = 1'b1;
    expect_ev(EV_GI, t + 1, '0, '0);
    for (int w = 0; w < 3; w++) expect_ev(EV_RD, t + 2 + w, I_BASE + 16'(w), '0);
    expect_ev(EV_RELI, t + 6, '0, '0);
    expect_fill(1'b1, t + 9, D_BASE);
    wait_until(t + 5);
    i_miss = 1'b0;
    #1;
    check("abort mem_enable", mem_enable, 1'b0);
    wait_until(t + 7);
    d_miss = 1'b1;
    wait_until(t + 23);
    d_miss = 1'b0;
    step(2);

    // Reset pulsed mid-fill, then a full fill restarts.
    t = cyc;
    i_miss = 1'b1;
    expect_ev(EV_GI, t + 1, '0, '0);
    expect_ev(EV_RD, t + 2, I_BASE, '0);
    expect_ev(EV_RD, t + 3, I_BASE + 16'd1, '0);
    expect_ev(EV_RELI, t + 4, '0, '0);
    wait_until(t + 4);
    rst_n = 1'b0;
    #1;
    check("midrst mem_enable",    mem_enable,    1'b0);
    check("midrst i_grant",       i_grant,       1'b0);
    check("midrst mem_addr",      mem_addr,      16'h0000);
    check("midrst i_force_reset", i_force_reset, 1'b1);
    wait_until(t + 6);
    rst_n = 1'b1;
    expect_fill(1'b0, t + 6, I_BASE);
    wait_until(t + 20);
    i_miss = 1'b0;

    step(20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      $display("FAIL missing %s at cycle %0d addr %h data %h", e.kind.name(), e.cyc, e.addr, e.data);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single multicycle main memory between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores. It sits between both caches and the memory model, grants one 8-word block fill or one single-word write at a time, and steers memory address, enable and read-valid to and from the owner. It holds non-owning fill FSMs in reset so that their counters start from zero when granted.

## Interface
- MEM_LAT, 4: cycles from read issue to mem_data_valid for that word.
- FILL_WORDS, 8: 16-bit words per block fill.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_miss, d_miss  in  1 each  fill request, held until the block is written.
- i_fill_addr, d_fill_addr  in  16 each  memory_address output of each fill FSM.
- d_wr_req  in  1  store request; held until d_wr_ack.
- d_wr_addr, d_wr_data  in  16 each  store address/data.
- mem_data_valid  in  1  read word returned by memory.
- mem_enable, mem_wr  out  1 each  memory strobe and write select.
- mem_addr, mem_wdata  out  16 each  memory address/write data.
- i_grant, d_grant  out  1 each  fill owner (one-hot or zero).
- i_data_valid, d_data_valid  out  1 each  mem_data_valid routed to the owner.
- i_force_reset, d_force_reset  out  1 each  drive the fill FSM's arb_force_reset.
- d_wr_ack  out  1  store accepted this cycle.

## Operation
- States: IDLE, WRITE, FILL_I, FILL_D, DRAIN.
- IDLE priority: d_wr_req > fill selection. With d_miss and i_miss both set, selection is round-robin by last_owner. Reset value of last_owner is I, so D wins the first tie.
- WRITE lasts one cycle: mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_ack=1. The next state is IDLE.
- FILL_x:
  - x_grant=1 and mem_addr=x_fill_addr.
  - mem_enable=1, mem_wr=0 while issue count < FILL_WORDS.
  - Each mem_data_valid increments the beat count and asserts x_data_valid in the same cycle, combinationally.
  - After the FILL_WORDS-th beat: IDLE, and last_owner becomes x.
- x_force_reset = x_miss & ~x_grant, combinational.
- Abort: if x_miss drops in FILL_x, mem_enable deasserts immediately and the state moves to DRAIN. DRAIN waits until beats received equals words issued, suppresses x_data_valid, and grant drops on entry to DRAIN. It then returns to IDLE.
- mem_data_valid in IDLE or WRITE is ignored and not routed.
- Issue and beat counters are 4 bits, cleared on every grant. They saturate at FILL_WORDS and never wrap.

## Timing
- Reset values:
  - state IDLE.
  - All grants, mem_enable, mem_wr, d_wr_ack and data_valids 0.
  - mem_addr and mem_wdata 0.
  - Counters 0.
  - force_reset equals miss.
- Request sampled in IDLE at cycle T; grant or WRITE is active in T+1.
- Fill: grant at G. mem_enable is high G+1..G+FILL_WORDS and low at G. The first beat is expected at G+1+MEM_LAT. Grant falls in the cycle after the last beat, so total occupancy is FILL_WORDS+MEM_LAT+1 cycles.
- Store latency: from d_wr_req to d_wr_ack is 1 cycle in IDLE, or until the current fill or drain completes otherwise.
- A request arriving in the same cycle the fill completes is evaluated in the following IDLE cycle. There is no back-to-back grant without an IDLE cycle.
- rst_n low mid-transaction: everything clears asynchronously and in-flight memory data is discarded.

## Configuration
- MEM_ARB_RR_EN defined: round-robin between fills as above.
- MEM_ARB_RR_EN undefined: fixed priority, D fill over I fill, and last_owner is not implemented. Store priority is unchanged in both builds.

## Structure
- Package mem_arb_pkg holds the state enum and the default constants FILL_WORDS and MEM_LAT.
- One sub-module, arb_xfer_counter: a 4-bit issue/beat counter pair with clear, saturation and done flags. It is instantiated once and shared by the fill states.

## Test plan
- Single I miss on 0x1234:
  - i_grant one cycle after i_miss.
  - mem_addr follows i_fill_addr.
  - 8 enables, then 8 i_data_valid starting 4 cycles after the first enable.
  - i_grant drops the cycle after beat 8.
- d_miss and i_miss raised together from reset:
  - With RR, D is served first, then I.
  - A repeated tie then alternates I, D.
  - Without the macro, D always wins.
- d_wr_req (0x00A0, 0xBEEF) raised during a D fill: held until the fill ends, then one cycle of mem_wr=1 with that addr/data and d_wr_ack=1.
- d_wr_req and i_miss in the same IDLE cycle: WRITE first, i_grant the cycle after IDLE is re-entered. i_force_reset stays 1 throughout.
- i_miss dropped after 3 issues: DRAIN absorbs 3 beats with no i_data_valid routed, then IDLE.
- rst_n pulsed low mid-fill: all outputs return to reset values immediately. A subsequent miss restarts a full 8-word fill.
